// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

  localparam int unsigned COUNT_W            = 24;
  localparam int unsigned LAP_W              = 4;
  localparam int unsigned DEBOUNCE_TICKS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUNNING  = 3'd1,
    ST_LAP      = 3'd2,
    ST_STOPPED  = 3'd3,
    ST_CLEARING = 3'd4
  } state_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, counter and display signals between the stopwatch controller and its
// surroundings. master = board/counter side, slave = controller.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic               i_startstop;
  logic               i_lap;
  logic               i_clear;
  logic [COUNT_W-1:0] i_count;
  logic               o_countenb;
  logic               o_latchcount;
  logic               o_countinit;
  logic [COUNT_W-1:0] o_display;
  logic [LAP_W-1:0]   o_lap_count;
  logic [2:0]         o_state;

  modport master (
    output i_startstop, i_lap, i_clear, i_count,
    input  o_countenb, o_latchcount, o_countinit, o_display, o_lap_count, o_state
  );

  modport slave (
    input  i_startstop, i_lap, i_clear, i_count,
    output o_countenb, o_latchcount, o_countinit, o_display, o_lap_count, o_state
  );

endinterface

// File: rtl/stopwatch_btn_cond.sv
// Button conditioning: 2-flop synchronizer, optional debounce, rising-edge
// event pulse. Debounce is built only when STOPWATCH_DEBOUNCE_EN is defined.
module stopwatch_btn_cond
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic i_rtcclk,
  input  logic i_reset,
  input  logic btn,
  output logic evt
);

  logic       sync1, sync2;
  logic [1:0] warm;
  logic       level, level_d, armed;

  if (DEBOUNCE_TICKS < 1) begin : g_cfg_check
    $error("DEBOUNCE_TICKS must be at least 1");
  end

  // Synchronize the raw level; warm marks when sync2 reflects a real sample.
  always_ff @(posedge i_rtcclk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      warm  <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
  logic [CW-1:0] db_cnt;
  logic          db_level;

  // Accept a new level only after it has been stable for DEBOUNCE_TICKS clocks.
  always_ff @(posedge i_rtcclk or posedge i_reset) begin
    if (i_reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DEBOUNCE_TICKS - 1)) begin
      db_level <= sync2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync2;
`endif

  // Registered rising-edge pulse. Edges are only armed once the button has
  // been seen genuinely released after reset, so a button held through reset
  // release does not fire.
  always_ff @(posedge i_rtcclk or posedge i_reset) begin
    if (i_reset) begin
      level_d <= 1'b0;
      armed   <= 1'b0;
      evt     <= 1'b0;
    end else begin
      level_d <= level;
      armed   <= armed | (warm[1] & ~sync2 & ~level);
      evt     <= armed & level & ~level_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop, lap freeze and clear sequencing.
// Optional debounce on the buttons via macro STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic             i_rtcclk,
  input  logic             i_reset,
  stopwatch_ctrl_if.slave  bus
);

  state_t             state;
  logic [COUNT_W-1:0] lap_reg;
  logic [LAP_W-1:0]   lap_count;
  logic               ev_ss, ev_lap, ev_clr;

  stopwatch_btn_cond #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_btn_ss (
    .i_rtcclk (i_rtcclk), .i_reset (i_reset), .btn (bus.i_startstop), .evt (ev_ss)
  );
  stopwatch_btn_cond #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_btn_lap (
    .i_rtcclk (i_rtcclk), .i_reset (i_reset), .btn (bus.i_lap), .evt (ev_lap)
  );
  stopwatch_btn_cond #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_btn_clr (
    .i_rtcclk (i_rtcclk), .i_reset (i_reset), .btn (bus.i_clear), .evt (ev_clr)
  );

  // Control FSM; start/stop outranks lap, lap outranks clear.
  always_ff @(posedge i_rtcclk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      lap_reg   <= '0;
      lap_count <= '0;
    end else begin
      case (state)
        ST_IDLE:     if (ev_ss) state <= ST_RUNNING;
        ST_RUNNING: begin
          if (ev_ss) begin
            state <= ST_STOPPED;
          end else if (ev_lap) begin
            state   <= ST_LAP;
            lap_reg <= bus.i_count;
            if (lap_count != '1) lap_count <= lap_count + 1'b1;
          end
        end
        ST_LAP: begin
          if (ev_ss)       state <= ST_STOPPED;
          else if (ev_lap) state <= ST_RUNNING;
        end
        ST_STOPPED: begin
          if (ev_ss)       state <= ST_RUNNING;
          else if (ev_clr) state <= ST_CLEARING;
        end
        ST_CLEARING: begin
          state     <= ST_IDLE;
          lap_count <= '0;
        end
        default:     state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_countenb   = (state == ST_RUNNING) || (state == ST_LAP);
  assign bus.o_latchcount = bus.o_countenb;
  assign bus.o_countinit  = (state == ST_CLEARING);
  assign bus.o_display    = (state == ST_LAP) ? lap_reg : bus.i_count;
  assign bus.o_lap_count  = lap_count;
  assign bus.o_state      = state;

endmodule
